run_control: RTL and testbench
==============================

RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameter ITER_W, default 24, width of the iteration count.
REQ-002 SHALL have parameter CYCLE_LEN, default 101, clocks per annealing iteration (node cycle 0..100).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
REQ-005 SHALL have port start  input  1  one-cycle request to begin a batch.
REQ-006 SHALL have port stop  input  1  one-cycle request to end the batch early.
REQ-007 SHALL have port iter_num  input  ITER_W  iterations per batch, sampled on accepted start.
REQ-008 SHALL have port opt_mode  input  opt_mode_t (2)  OR1_ONLY, TWO_ONLY, ALTERNATE or RANDOM; sampled on accepted start.
REQ-009 SHALL have port rand_bit  input  1  random bit used in RANDOM mode.
REQ-010 SHALL have port run  output  1  one-cycle pulse starting one node iteration.
REQ-011 SHALL have port opt_command  output  opt_command_t  move type for the current iteration.
REQ-012 SHALL have port busy  output  1  high from accepted start until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse at batch end.
REQ-014 SHALL have port iter_cnt  output  ITER_W  iterations issued in the current or last batch.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | FIN) -> IDLE.
REQ-016 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-017 IDLE, start, iter_num!=0: SHALL go to ISSUE; run=1 in the next cycle.
REQ-018 IDLE, start, iter_num==0: SHALL go straight to FIN with no run pulse; done follows 1 cycle after start.
REQ-019 ISSUE: SHALL assert run for exactly one cycle, increment iter_cnt, and go to WAIT.
REQ-020 WAIT: SHALL count CYCLE_LEN-1 cycles, giving a spacing of exactly CYCLE_LEN clocks between consecutive run pulses.
REQ-021 At WAIT end: SHALL go to ISSUE if iter_cnt<iter_num and no stop is pending, else to FIN.
REQ-022 FIN: SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-023 SHALL register stop when busy, as a sticky flag cleared in FIN; the iteration in progress always completes, so a node cycle is never truncated.
REQ-024 stop in IDLE SHALL be ignored.
REQ-025 SHALL update opt_command only in the cycle that run is high; it SHALL hold for the whole iteration.
REQ-026 opt_command per mode:
- OR1_ONLY: always OR1.
- TWO_ONLY: always TWO.
- ALTERNATE: OR1 on the first iteration, then toggle.
- RANDOM: rand_bit ? TWO : OR1, sampled in the ISSUE cycle.
REQ-027 SHALL clear iter_cnt on accepted start and hold it after done until the next start.
REQ-028 SHALL keep iter_cnt arithmetic at ITER_W bits with no wrap; the maximum is iter_num (max 2^ITER_W-1).
REQ-029 Simultaneous stop and the last WAIT cycle: SHALL go to FIN, with no extra run.

Reset
REQ-030 On reset==0: state=IDLE, run=0, done=0, busy=0, iter_cnt=0, opt_command=OR1, stop flag=0, wait counter=0.
REQ-031 Reset mid-batch SHALL abort immediately with no done pulse; the first cycle after reset is IDLE.

Structure
REQ-032 opt_mode_t and the CYCLE_LEN default SHALL live in replica_pkg beside opt_command_t.
REQ-033 SHALL be a single module with no sub-module; the WAIT counter width is $clog2(CYCLE_LEN).

Verification
REQ-034 iter_num=3, OR1_ONLY, start at t0 -> run at t0+1, t0+102, t0+203; done at t0+304; iter_cnt=3.
REQ-035 iter_num=4, ALTERNATE -> opt_command OR1, TWO, OR1, TWO, each held stable across its 101 cycles.
REQ-036 iter_num=0, start -> done 1 cycle later, no run pulse, busy high for 1 cycle.
REQ-037 iter_num=10, stop 50 cycles after the 2nd run -> no 3rd run; done 101 cycles after the 2nd run; iter_cnt=2.
REQ-038 Second start while busy, plus reset=0 asserted mid-WAIT -> the second start is ignored; after reset, busy=0, done never pulses, iter_cnt=0.

Source files
------------

// File: rtl/replica_pkg.sv
// ---------------------------------------------------------------------------
// replica_pkg
// Shared types and constants for the replica annealing control path.
//   opt_command_t : move type applied to the nodes during one iteration
//   opt_mode_t    : how the move type is chosen across a batch
//   run_state_t   : run_control sequencing states
//   CYCLE_LEN_DEFAULT : clocks per annealing iteration (node cycle 0..100)
//   next_command() : move type selection for the next iteration
// ---------------------------------------------------------------------------
package replica_pkg;

   localparam int CYCLE_LEN_DEFAULT = 101;

   typedef enum logic {
      OR1 = 1'b0,
      TWO = 1'b1
   } opt_command_t;

   typedef enum logic [1:0] {
      OR1_ONLY  = 2'd0,
      TWO_ONLY  = 2'd1,
      ALTERNATE = 2'd2,
      RANDOM    = 2'd3
   } opt_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FIN   = 2'd3
   } run_state_t;

   // Move type for the next iteration. 'first' marks the first iteration of a
   // batch so ALTERNATE always opens with OR1 regardless of the previous batch.
   function automatic opt_command_t next_command(input opt_mode_t    mode,
                                                 input logic         first,
                                                 input opt_command_t prev,
                                                 input logic         rnd);
      opt_command_t cmd;
      cmd = OR1;
      case (mode)
         OR1_ONLY:  cmd = OR1;
         TWO_ONLY:  cmd = TWO;
         ALTERNATE: cmd = (first || prev == TWO) ? OR1 : TWO;
         default:   cmd = rnd ? TWO : OR1;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/run_control.sv
// ---------------------------------------------------------------------------
// run_control
// Batch sequencer for the annealing node array. On an accepted start it issues
// iter_num one-cycle run pulses spaced exactly CYCLE_LEN clocks apart, selects
// the move type for each iteration, and pulses done at the end of the batch.
// A stop request ends the batch after the iteration in progress completes.
//
// Ports
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous reset, active low
//   start        in   one-cycle batch request (accepted only when idle)
//   stop         in   one-cycle early-termination request (ignored when idle)
//   iter_num     in   iterations per batch, sampled on accepted start
//   opt_mode     in   move-type selection mode, sampled on accepted start
//   rand_bit     in   random bit for RANDOM mode
//   run          out  one-cycle pulse starting one node iteration
//   opt_command  out  move type for the current iteration
//   busy         out  high from accepted start through the done cycle
//   done         out  one-cycle pulse at batch end
//   iter_cnt     out  iterations issued in the current or last batch
// ---------------------------------------------------------------------------
module run_control
   import replica_pkg::*;
#(
   parameter int ITER_W    = 24,
   parameter int CYCLE_LEN = CYCLE_LEN_DEFAULT   // must be at least 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [ITER_W-1:0] iter_num,
   input  opt_mode_t         opt_mode,
   input  logic              rand_bit,
   output logic              run,
   output opt_command_t      opt_command,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_cnt
);

   localparam int CNT_W = $clog2(CYCLE_LEN);
   // WAIT lasts CYCLE_LEN-1 cycles (count 0..CYCLE_LEN-2); together with the
   // single ISSUE cycle that spaces run pulses exactly CYCLE_LEN clocks apart.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CYCLE_LEN - 2);

   run_state_t        state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ITER_W-1:0] iter_num_q;
   opt_mode_t         opt_mode_q;
   logic              stop_flag;

   // All outputs are registered: run, opt_command and iter_cnt are loaded on
   // the edge that enters ISSUE, so they are all valid in the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         run         <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         iter_cnt    <= '0;
         opt_command <= OR1;
         stop_flag   <= 1'b0;
         wait_cnt    <= '0;
         iter_num_q  <= '0;
         opt_mode_q  <= OR1_ONLY;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment to the
         // same register in this block (e.g. stop_flag in ST_FIN) overrides the
         // default set here.
         run  <= 1'b0;
         done <= 1'b0;
         if (busy && stop) begin
            stop_flag <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  iter_num_q <= iter_num;
                  opt_mode_q <= opt_mode;
                  busy       <= 1'b1;
                  stop_flag  <= 1'b0;
                  wait_cnt   <= '0;
                  if (iter_num != '0) begin
                     state       <= ST_ISSUE;
                     run         <= 1'b1;
                     iter_cnt    <= ITER_W'(1);
                     opt_command <= next_command(opt_mode, 1'b1, opt_command, rand_bit);
                  end else begin
                     state    <= ST_FIN;
                     done     <= 1'b1;
                     iter_cnt <= '0;
                  end
               end
            end

            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end

            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  // A stop arriving in the last WAIT cycle still ends the batch.
                  if (iter_cnt < iter_num_q && !stop_flag && !stop) begin
                     state       <= ST_ISSUE;
                     run         <= 1'b1;
                     iter_cnt    <= iter_cnt + 1'b1;
                     opt_command <= next_command(opt_mode_q, 1'b0, opt_command, rand_bit);
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_FIN: begin
               // busy falls on the same edge that ends the done pulse.
               state     <= ST_IDLE;
               busy      <= 1'b0;
               stop_flag <= 1'b0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_control.sv
// ---------------------------------------------------------------------------
// tb_run_control
// Directed bench for run_control with hand-computed pulse timing. Cycle k of
// a batch is the k-th clock after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_run_control;
   import replica_pkg::*;

   logic         clk;
   logic         reset;
   logic         start;
   logic         stop;
   logic [23:0]  iter_num;
   opt_mode_t    opt_mode;
   logic         rand_bit;
   logic         run;
   opt_command_t opt_command;
   logic         busy;
   logic         done;
   logic [23:0]  iter_cnt;

   int checks = 0;
   int errors = 0;

   int           runs[$];
   opt_command_t cmds[$];
   int           done_at;
   int           busy_low;
   int           unstable;

   run_control #(.ITER_W(24), .CYCLE_LEN(101)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .iter_num    (iter_num),
      .opt_mode    (opt_mode),
      .rand_bit    (rand_bit),
      .run         (run),
      .opt_command (opt_command),
      .busy        (busy),
      .done        (done),
      .iter_cnt    (iter_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int run_at(input int i);
      return (i < runs.size()) ? runs[i] : -1;
   endfunction

   function automatic int cmd_at(input int i);
      return (i < cmds.size()) ? int'(cmds[i]) : -1;
   endfunction

   task automatic do_start(input logic [23:0] n, input opt_mode_t m);
      iter_num = n;
      opt_mode = m;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Follows one batch from cycle 1 until done or the budget runs out.
   // Optionally pulses stop at runs[stop_idx]+stop_delay and flips rand_bit
   // mid-iteration so each RANDOM sample sees a stable value.
   task automatic observe(input int budget, input int stop_idx, input int stop_delay,
                          input bit flip_rand);
      opt_command_t held;
      runs.delete();
      cmds.delete();
      done_at  = -1;
      busy_low = 0;
      unstable = 0;
      held     = opt_command;
      for (int k = 1; k <= budget; k++) begin
         if (!busy) busy_low++;
         if (run) begin
            runs.push_back(k);
            cmds.push_back(opt_command);
            held = opt_command;
         end else if (opt_command != held) begin
            unstable++;
         end
         if (done) begin
            done_at = k;
            break;
         end
         stop = (stop_idx >= 0 && runs.size() > stop_idx && k == run_at(stop_idx) + stop_delay);
         if (flip_rand && runs.size() > 0 && k == runs[runs.size()-1] + 50)
            rand_bit = ~rand_bit;
         tick();
      end
      stop = 1'b0;
   endtask

   task automatic check_after_done(input string tag, input int exp_cnt);
      tick();
      check({tag, "_done_clears"}, done, 0);
      check({tag, "_busy_clears"}, busy, 0);
      check({tag, "_iter_cnt_held"}, iter_cnt, exp_cnt);
   endtask

   initial begin
      int seen_run;
      int seen_done;

      reset    = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      iter_num = '0;
      opt_mode = OR1_ONLY;
      rand_bit = 1'b0;
      repeat (3) tick();
      check("rst_run", run, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_iter_cnt", iter_cnt, 0);
      check("rst_opt_command", opt_command, OR1);
      reset = 1'b1;
      tick();

      // Three OR1 iterations: runs at 1, 102, 203; done at 304.
      do_start(24'd3, OR1_ONLY);
      observe(400, -1, 0, 1'b0);
      check("a_run_count", runs.size(), 3);
      check("a_run0", run_at(0), 1);
      check("a_run1", run_at(1), 102);
      check("a_run2", run_at(2), 203);
      check("a_done_at", done_at, 304);
      check("a_iter_cnt", iter_cnt, 3);
      check("a_cmd0", cmd_at(0), OR1);
      check("a_cmd2", cmd_at(2), OR1);
      check("a_busy_low", busy_low, 0);
      check("a_unstable", unstable, 0);
      check_after_done("a", 3);

      // Zero iterations: done in cycle 1, no run, busy high only that cycle.
      tick();
      do_start(24'd0, TWO_ONLY);
      check("z_busy_cycle1", busy, 1);
      check("z_iter_cnt_cleared", iter_cnt, 0);
      observe(10, -1, 0, 1'b0);
      check("z_done_at", done_at, 1);
      check("z_run_count", runs.size(), 0);
      check_after_done("z", 0);

      // Stop 50 cycles after the second run: no third run, done 101 later.
      tick();
      do_start(24'd10, TWO_ONLY);
      observe(1200, 1, 50, 1'b0);
      check("s_run_count", runs.size(), 2);
      check("s_run1", run_at(1), 102);
      check("s_done_at", done_at, 203);
      check("s_iter_cnt", iter_cnt, 2);
      check("s_cmd1", cmd_at(1), TWO);
      check_after_done("s", 2);

      // ALTERNATE opens with OR1 even though the last command was TWO.
      tick();
      do_start(24'd4, ALTERNATE);
      observe(500, -1, 0, 1'b0);
      check("alt_run_count", runs.size(), 4);
      check("alt_cmd0", cmd_at(0), OR1);
      check("alt_cmd1", cmd_at(1), TWO);
      check("alt_cmd2", cmd_at(2), OR1);
      check("alt_cmd3", cmd_at(3), TWO);
      check("alt_run3", run_at(3), 304);
      check("alt_done_at", done_at, 405);
      check("alt_unstable", unstable, 0);
      check("alt_iter_cnt", iter_cnt, 4);
      tick();

      // Stop in the last WAIT cycle (cycle 101) ends the batch with no 2nd run.
      tick();
      do_start(24'd5, OR1_ONLY);
      observe(700, 0, 100, 1'b0);
      check("lw_run_count", runs.size(), 1);
      check("lw_done_at", done_at, 102);
      check("lw_iter_cnt", iter_cnt, 1);
      tick();

      // Stop while idle is ignored: a following 2-iteration batch runs fully.
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      do_start(24'd2, OR1_ONLY);
      observe(300, -1, 0, 1'b0);
      check("is_run_count", runs.size(), 2);
      check("is_done_at", done_at, 203);
      tick();

      // RANDOM: rand_bit 1, then 0, then 1 across the three iterations.
      tick();
      rand_bit = 1'b1;
      do_start(24'd3, RANDOM);
      observe(400, -1, 0, 1'b1);
      check("rnd_cmd0", cmd_at(0), TWO);
      check("rnd_cmd1", cmd_at(1), OR1);
      check("rnd_cmd2", cmd_at(2), TWO);
      check("rnd_unstable", unstable, 0);
      check("rnd_done_at", done_at, 304);
      tick();

      // Second start mid-WAIT is ignored, then reset aborts the batch.
      tick();
      do_start(24'd5, OR1_ONLY);
      repeat (20) tick();
      iter_num = 24'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check("ss_busy", busy, 1);
      check("ss_iter_cnt", iter_cnt, 1);
      seen_done = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) seen_done++;
         tick();
      end
      check("ss_no_done", seen_done, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mr_busy", busy, 0);
      check("mr_iter_cnt", iter_cnt, 0);
      check("mr_run", run, 0);
      check("mr_opt_command", opt_command, OR1);
      seen_run  = 0;
      seen_done = 0;
      for (int k = 0; k < 250; k++) begin
         if (run) seen_run++;
         if (done) seen_done++;
         tick();
      end
      check("mr_no_run", seen_run, 0);
      check("mr_no_done", seen_done, 0);
      check("mr_busy_idle", busy, 0);

      // Recovery: a one-iteration batch runs normally after the reset.
      do_start(24'd1, TWO_ONLY);
      observe(200, -1, 0, 1'b0);
      check("rc_run0", run_at(0), 1);
      check("rc_done_at", done_at, 102);
      check("rc_cmd0", cmd_at(0), TWO);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
